// File: rtl/tmds_period_scheduler.sv
// -----------------------------------------------------------------------------
// tmds_period_scheduler
//
// Chooses, once per pixel clock, what the three TMDS channel encoders send:
// control, video preamble, video guard band or video data. Pixel and sync
// inputs are delayed so that the preamble and guard band fit in ahead of each
// active-video run. Also drives CTL0..3 and the running-disparity clear for
// the stage-2 encoders.
//
// Build option:
//   HDMI_PREAMBLE_EN defined   : preamble + guard band insertion,
//                                latency LAT = PRE_LEN+GB_LEN+1.
//   HDMI_PREAMBLE_EN undefined : DVI mode, latency 1, period only CTRL/VIDEO,
//                                ctl and short_blank tied low.
//
// Parameters:
//   PRE_LEN  video preamble length in clocks (1..15)
//   GB_LEN   video leading guard band length in clocks (1..3)
//   CTL_MIN  plain-control clocks needed before a preamble may start (1..31)
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   de_in, hsync_in,
//   vsync_in, rgb_in         timing generator outputs (de_in also lookahead)
//   rgb_out, hsync_out,
//   vsync_out                inputs delayed by LAT clocks
//   period                   00 CTRL, 01 PREAMBLE, 10 GUARD, 11 VIDEO
//   ctl                      {CTL3,CTL2,CTL1,CTL0}
//   rd_clear                 force encoder running disparity to 0
//   short_blank              1-clock pulse when a preamble had to be dropped
// -----------------------------------------------------------------------------
module tmds_period_scheduler #(
   parameter int unsigned PRE_LEN = 8,
   parameter int unsigned GB_LEN  = 2,
   parameter int unsigned CTL_MIN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [23:0] rgb_in,
   output logic [23:0] rgb_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [1:0]  period,
   output logic [3:0]  ctl,
   output logic        rd_clear,
   output logic        short_blank
);

`ifdef HDMI_PREAMBLE_EN
   localparam int unsigned LAT = PRE_LEN + GB_LEN + 1;
`else
   localparam int unsigned LAT = 1;
`endif
   localparam int unsigned DW = 27;   // {de, hsync, vsync, rgb}

   if (PRE_LEN < 1 || PRE_LEN > 15 || GB_LEN < 1 || GB_LEN > 3 ||
       CTL_MIN < 1 || CTL_MIN > 31) begin : g_bad_param
      $error("tmds_period_scheduler: parameter out of range");
   end

   typedef enum logic [1:0] {
      PER_CTRL  = 2'b00,
      PER_PRE   = 2'b01,
      PER_GUARD = 2'b10,
      PER_VIDEO = 2'b11
   } period_e;

   // ---------------------------------------------------------------------------
   // Delay line: stage 0 captures the inputs, stage LAT-1 is the output tap.
   // ---------------------------------------------------------------------------
   logic [DW-1:0] dl_q [LAT];
   logic [DW-1:0] dl_d [LAT];
   logic          de_nx;   // value the delayed de will take after this edge

   always_comb begin
      dl_d[0] = {de_in, hsync_in, vsync_in, rgb_in};
      for (int unsigned i = 1; i < LAT; i++) begin
         dl_d[i] = dl_q[i-1];
      end
      de_nx = dl_d[LAT-1][DW-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            dl_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < LAT; i++) begin
            dl_q[i] <= dl_d[i];
         end
      end
   end

   assign hsync_out = dl_q[LAT-1][25];
   assign vsync_out = dl_q[LAT-1][24];
   assign rgb_out   = dl_q[LAT-1][23:0];

   period_e period_q, period_d;
   logic    rd_clear_q, rd_clear_d;

   assign period   = period_q;
   assign rd_clear = rd_clear_q;

`ifdef HDMI_PREAMBLE_EN
   typedef enum logic [1:0] {
      ST_CTRL,
      ST_PRE,
      ST_GUARD,
      ST_VIDEO
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  dcnt_q, dcnt_d;        // preamble / guard down-counter
   logic [5:0]  ctl_cnt_q, ctl_cnt_d;  // consecutive CTRL output clocks
   logic        de_prev_q, de_prev_d;
   logic [3:0]  ctl_q, ctl_d;
   logic        short_blank_q, short_blank_d;
   logic        rise;
   logic        blank_ok;

   assign rise     = de_in & ~de_prev_q;
   // The +1 accounts for the current clock, which is still a CTRL clock.
   assign blank_ok = (7'(ctl_cnt_q) + 7'd1) >= 7'(CTL_MIN);

   always_comb begin
      state_d       = state_q;
      dcnt_d        = dcnt_q;
      de_prev_d     = de_in;
      short_blank_d = 1'b0;

      ctl_cnt_d = '0;
      if (period_q == PER_CTRL) begin
         ctl_cnt_d = (ctl_cnt_q == '1) ? ctl_cnt_q : ctl_cnt_q + 6'd1;
      end

      // de_in is the lookahead: a rise here becomes visible at the output
      // LAT clocks later, exactly after the preamble and guard band.
      unique case (state_q)
         ST_CTRL: begin
            if (rise && blank_ok) begin
               state_d = ST_PRE;
               dcnt_d  = 4'(PRE_LEN - 1);
            end else begin
               if (rise) short_blank_d = 1'b1;
               if (de_nx) state_d = ST_VIDEO;
            end
         end
         ST_PRE: begin
            if (rise) short_blank_d = 1'b1;
            if (dcnt_q == '0) begin
               state_d = ST_GUARD;
               dcnt_d  = 4'(GB_LEN - 1);
            end else begin
               dcnt_d = dcnt_q - 4'd1;
            end
         end
         ST_GUARD: begin
            if (rise) short_blank_d = 1'b1;
            if (dcnt_q == '0) begin
               state_d = ST_VIDEO;
            end else begin
               dcnt_d = dcnt_q - 4'd1;
            end
         end
         default: begin
            if (rise) short_blank_d = 1'b1;
            if (!de_nx) state_d = ST_CTRL;
         end
      endcase

      // Delayed de overrides the state so VIDEO tracks de_d exactly.
      if (de_nx) begin
         period_d = PER_VIDEO;
      end else if (state_d == ST_PRE) begin
         period_d = PER_PRE;
      end else if (state_d == ST_GUARD) begin
         period_d = PER_GUARD;
      end else begin
         period_d = PER_CTRL;
      end

      ctl_d      = (period_d == PER_PRE) ? 4'b0001 : 4'b0000;
      rd_clear_d = (period_d != PER_VIDEO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_CTRL;
         dcnt_q        <= '0;
         ctl_cnt_q     <= '0;
         de_prev_q     <= 1'b0;
         period_q      <= PER_CTRL;
         ctl_q         <= '0;
         rd_clear_q    <= 1'b0;
         short_blank_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dcnt_q        <= dcnt_d;
         ctl_cnt_q     <= ctl_cnt_d;
         de_prev_q     <= de_prev_d;
         period_q      <= period_d;
         ctl_q         <= ctl_d;
         rd_clear_q    <= rd_clear_d;
         short_blank_q <= short_blank_d;
      end
   end

   assign ctl         = ctl_q;
   assign short_blank = short_blank_q;
`else
   always_comb begin
      period_d   = de_nx ? PER_VIDEO : PER_CTRL;
      rd_clear_d = ~de_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_q   <= PER_CTRL;
         rd_clear_q <= 1'b0;
      end else begin
         period_q   <= period_d;
         rd_clear_q <= rd_clear_d;
      end
   end

   assign ctl         = '0;
   assign short_blank = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tmds_period_scheduler
//
// Drives a fixed sequence of lines (reset with de high, a normal line, a line
// after a 5-clock blank, a line interrupted by reset in its 4th preamble
// clock, lines after 14- and 13-clock blanks) and logs inputs and outputs per
// clock. Expected outputs are then derived from the logged inputs: delayed
// copies masked by reset, plus hand-placed preamble/guard windows and
// short_blank pulses.
// -----------------------------------------------------------------------------
module tb_tmds_period_scheduler;

`ifdef HDMI_PREAMBLE_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 1;
`endif
   localparam int N = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic        de_in, hsync_in, vsync_in;
   logic [23:0] rgb_in;
   logic [23:0] rgb_out;
   logic        hsync_out, vsync_out;
   logic [1:0]  period;
   logic [3:0]  ctl;
   logic        rd_clear, short_blank;

   tmds_period_scheduler #(
      .PRE_LEN (8),
      .GB_LEN  (2),
      .CTL_MIN (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .de_in       (de_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .rgb_in      (rgb_in),
      .rgb_out     (rgb_out),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .period      (period),
      .ctl         (ctl),
      .rd_clear    (rd_clear),
      .short_blank (short_blank)
   );

   always #5 clk = ~clk;

   // Per-cycle logs: inputs of cycle c, outputs observed during cycle c.
   logic        in_rst [N];
   logic        in_de  [N];
   logic        in_hs  [N];
   logic        in_vs  [N];
   logic [23:0] in_rgb [N];
   logic [1:0]  o_per  [N];
   logic [3:0]  o_ctl  [N];
   logic        o_rdc  [N];
   logic        o_sb   [N];
   logic        o_hs   [N];
   logic        o_vs   [N];
   logic [23:0] o_rgb  [N];
   logic [1:0]  e_per  [N];

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int ra, rb, rc, rd, re;

   task automatic check_eq(input string tag, input int c,
                           input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, c, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic de);
      if (cyc >= N - 1) begin
         $display("FAIL log_overflow @cycle %0d: got %0d, expected < %0d", cyc, cyc, N - 1);
         $fatal(1, "log overflow");
      end
      rst      = r;
      de_in    = de;
      hsync_in = (cyc % 7) < 2;
      vsync_in = (cyc % 11) == 3;
      rgb_in   = 24'h0A0000 + 24'(cyc);
      in_rst[cyc] = r;
      in_de[cyc]  = de;
      in_hs[cyc]  = hsync_in;
      in_vs[cyc]  = vsync_in;
      in_rgb[cyc] = rgb_in;
      @(posedge clk);
      #1;
      cyc++;
      o_per[cyc] = period;
      o_ctl[cyc] = ctl;
      o_rdc[cyc] = rd_clear;
      o_sb[cyc]  = short_blank;
      o_hs[cyc]  = hsync_out;
      o_vs[cyc]  = vsync_out;
      o_rgb[cyc] = rgb_out;
   endtask

   task automatic run(input int n, input logic de);
      repeat (n) drive(1'b0, de);
   endtask

   initial begin
      // Reset held 3 clocks with de_in high, released with de_in low.
      repeat (3) drive(1'b1, 1'b1);
      run(20, 1'b0);
      ra = cyc; run(16, 1'b1);              // line A: full preamble
      run(5, 1'b0);
      rb = cyc; run(16, 1'b1);              // line B: blank too short
      run(20, 1'b0);
      rc = cyc; run(4, 1'b1);               // line C: reset in 4th preamble clock
      drive(1'b1, 1'b1);
      run(11, 1'b1);
      run(14, 1'b0);
      rd = cyc; run(16, 1'b1);              // line D: 14-clock blank, just enough
      run(13, 1'b0);
      re = cyc; run(16, 1'b1);              // line E: 13-clock blank, one short
      run(20, 1'b0);

      for (int c = 1; c <= cyc; c++) begin
         logic        masked;
         logic        de_e;
         logic        hs_e, vs_e;
         logic [23:0] rgb_e;
         logic [3:0]  ctl_e;
         logic        rdc_e;
         masked = 1'b0;
         for (int j = c - LAT; j < c; j++) begin
            if (j < 0 || in_rst[j]) masked = 1'b1;
         end
         de_e  = masked ? 1'b0  : in_de[c-LAT];
         hs_e  = masked ? 1'b0  : in_hs[c-LAT];
         vs_e  = masked ? 1'b0  : in_vs[c-LAT];
         rgb_e = masked ? 24'h0 : in_rgb[c-LAT];
         e_per[c] = de_e ? 2'b11 : 2'b00;
`ifdef HDMI_PREAMBLE_EN
         if ((c >= ra + 1 && c <= ra + 8) || (c >= rd + 1 && c <= rd + 8) ||
             (c >= rc + 1 && c <= rc + 4)) begin
            e_per[c] = 2'b01;
         end
         if ((c >= ra + 9 && c <= ra + 10) || (c >= rd + 9 && c <= rd + 10)) begin
            e_per[c] = 2'b10;
         end
`endif
         ctl_e = (e_per[c] == 2'b01) ? 4'b0001 : 4'b0000;
         rdc_e = in_rst[c-1] ? 1'b0 : (e_per[c] != 2'b11);
         check_eq("period",    c, 32'(o_per[c]), 32'(e_per[c]));
         check_eq("ctl",       c, 32'(o_ctl[c]), 32'(ctl_e));
         check_eq("rd_clear",  c, 32'(o_rdc[c]), 32'(rdc_e));
         check_eq("rgb_out",   c, 32'(o_rgb[c]), 32'(rgb_e));
         check_eq("hsync_out", c, 32'(o_hs[c]),  32'(hs_e));
         check_eq("vsync_out", c, 32'(o_vs[c]),  32'(vs_e));
      end

`ifdef HDMI_PREAMBLE_EN
      // Around the reset in line C the pulse is left unchecked.
      for (int c = 1; c <= rc; c++) begin
         check_eq("short_blank", c, 32'(o_sb[c]), 32'(c == rb + 1));
      end
      for (int c = rd; c <= cyc; c++) begin
         check_eq("short_blank", c, 32'(o_sb[c]), 32'(c == re + 1));
      end
`else
      for (int c = 1; c <= cyc; c++) begin
         check_eq("short_blank", c, 32'(o_sb[c]), 32'h0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
